// File: rtl/calc_seq_pkg.sv
// calc_seq_pkg: shared types and constants for the calculator sequencer.
//   state_e       : sequencer state encoding (exposed on state_o)
//   OP_*          : datapath opcode values driven on fpu_op
//   FLG_*         : bit positions inside the 5-bit fpu_flags / flags vectors
//   opcode_ok()   : a switch word is a legal opcode when only bits [1:0] may be set
package calc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GOT_A = 3'd1,
    ST_GOT_B = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FLG_UNDERFLOW = 4;
  localparam int FLG_OVERFLOW  = 3;
  localparam int FLG_INEXACT   = 2;
  localparam int FLG_EXCEPTION = 1;
  localparam int FLG_INVALID   = 0;

  function automatic logic opcode_ok(input logic [15:0] sw);
    return (sw[15:2] == 14'd0);
  endfunction

endpackage

// File: rtl/calc_seq_debounce.sv
// calc_seq_debounce: level filter for the push-button input.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   i_level   : raw button level
//   o_level   : filtered level; follows i_level only after it has held the
//               new value for DEBOUNCE_CYCLES consecutive cycles
// The filtered level resets high so a button held through reset is not
// mistaken for a fresh press.
module calc_seq_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Counter tracks how long the input has disagreed with the output; any
  // cycle of agreement restarts the count, so a short glitch never flips it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else if (i_level == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= i_level;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: push-button sequencer feeding an external FP datapath.
// Three presses load operand A, operand B and the opcode; the op is then
// launched with a one-cycle fpu_start and the result (or timeout) latched.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   enable            : push-button level, a rising edge is a press
//   switches[15:0]    : operand / opcode entry
//   fpu_ready         : datapath result valid (only looked at in WAIT)
//   fpu_sum[15:0]     : datapath result
//   fpu_flags[4:0]    : {underflow, overflow, inexact, exception, invalid}
//   opa, opb, fpu_op  : operands and opcode to the datapath
//   fpu_start         : launch pulse, high only in ISSUE
//   result, flags     : latched result and flags
//   result_valid, busy, timeout, op_err : status
//   state_o[2:0]      : current state encoding
// Build option: define CALC_SEQ_DEBOUNCE_EN to insert the debounce filter
// (calc_seq_debounce) on enable; otherwise enable is edge-detected raw and
// DEBOUNCE_CYCLES has no effect.
module calc_seq_ctrl
  import calc_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] switches,
  input  logic        fpu_ready,
  input  logic [15:0] fpu_sum,
  input  logic [4:0]  fpu_flags,
  output logic [15:0] opa,
  output logic [15:0] opb,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  output logic [15:0] result,
  output logic [4:0]  flags,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout,
  output logic        op_err,
  output logic [2:0]  state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- press
  logic w_level;

`ifdef CALC_SEQ_DEBOUNCE_EN
  calc_seq_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_level (enable),
    .o_level (w_level)
  );
`else
  assign w_level = enable;
`endif

  // enable_q resets high: a button already down when reset releases must be
  // let go before it can count as a press.
  logic r_enable_q;
  logic w_press;

  always_ff @(posedge clk) begin
    if (rst) r_enable_q <= 1'b1;
    else     r_enable_q <= w_level;
  end

  assign w_press = w_level & ~r_enable_q;

  // ---------------------------------------------------------------- FSM
  state_e        r_state, w_state_nxt;
  logic [15:0]   r_opa, w_opa_nxt;
  logic [15:0]   r_opb, w_opb_nxt;
  logic [1:0]    r_op, w_op_nxt;
  logic [15:0]   r_result, w_result_nxt;
  logic [4:0]    r_flags, w_flags_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_op_err, w_op_err_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_op      <= OP_ADD;
      r_result  <= '0;
      r_flags   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_op_err  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_opa     <= w_opa_nxt;
      r_opb     <= w_opb_nxt;
      r_op      <= w_op_nxt;
      r_result  <= w_result_nxt;
      r_flags   <= w_flags_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_op_err  <= w_op_err_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_opa_nxt     = r_opa;
    w_opb_nxt     = r_opb;
    w_op_nxt      = r_op;
    w_result_nxt  = r_result;
    w_flags_nxt   = r_flags;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = r_timeout;
    w_op_err_nxt  = r_op_err;
    // Counter is zero everywhere except while waiting, so every WAIT entry
    // starts from 0.
    w_cnt_nxt     = '0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_press) begin
          w_opa_nxt     = switches;
          w_result_nxt  = '0;
          w_flags_nxt   = '0;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
          w_op_err_nxt  = 1'b0;
          w_state_nxt   = ST_GOT_A;
        end
      end
      ST_GOT_A: begin
        if (w_press) begin
          w_opb_nxt   = switches;
          w_state_nxt = ST_GOT_B;
        end
      end
      ST_GOT_B: begin
        if (w_press) begin
          if (opcode_ok(switches)) begin
            w_op_nxt    = switches[1:0];
            w_state_nxt = ST_ISSUE;
          end else begin
            w_op_err_nxt = 1'b1;
            w_result_nxt = '0;
            w_flags_nxt  = '0;
            w_state_nxt  = ST_DONE;
          end
        end
      end
      // Any fpu_ready seen here belongs to nothing we launched; ignore it.
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // fpu_ready is tested first so it beats a same-cycle expiry.
        if (fpu_ready) begin
          w_result_nxt = fpu_sum;
          w_flags_nxt  = fpu_flags;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = ST_DONE;
        end else if (w_cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          w_timeout_nxt = 1'b1;
          w_result_nxt  = '0;
          w_flags_nxt   = '0;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign opa          = r_opa;
  assign opb          = r_opb;
  assign fpu_op       = r_op;
  assign result       = r_result;
  assign flags        = r_flags;
  assign result_valid = r_valid;
  assign timeout      = r_timeout;
  assign op_err       = r_op_err;
  assign fpu_start    = (r_state == ST_ISSUE);
  assign busy         = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign state_o      = r_state;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;

  localparam int T  = 8;
  localparam int DB = 4;
`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int LAT = DB;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] switches;
  logic        fpu_ready;
  logic [15:0] fpu_sum;
  logic [4:0]  fpu_flags;
  logic [15:0] opa, opb, result;
  logic [1:0]  fpu_op;
  logic        fpu_start, result_valid, busy, timeout, op_err;
  logic [4:0]  flags;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_seq_ctrl #(
    .TIMEOUT_CYCLES  (T),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .switches     (switches),
    .fpu_ready    (fpu_ready),
    .fpu_sum      (fpu_sum),
    .fpu_flags    (fpu_flags),
    .opa          (opa),
    .opb          (opb),
    .fpu_op       (fpu_op),
    .fpu_start    (fpu_start),
    .result       (result),
    .flags        (flags),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout      (timeout),
    .op_err       (op_err),
    .state_o      (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One button press: held long enough to pass the filter, then released
  // long enough for the filter to fall again.
  task automatic press(input logic [15:0] sw);
    switches = sw;
    enable   = 1'b1;
    repeat (LAT + 1) tick();
    enable   = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  // Full command. Expected outcome comes straight from the rules:
  // illegal opcode -> op_err; ready on WAIT cycle d < T -> result latched;
  // otherwise timeout after exactly T WAIT cycles. pw = WAIT cycle with a
  // stray press (out of range means none).
  task automatic run_txn(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] opsw, input int d, input logic [15:0] sum,
                         input logic [4:0] flg, input int pw);
    logic        bad, to, rv;
    logic [15:0] er;
    logic [4:0]  ef;
    bit          fin;
    bad = (opsw[15:2] != 14'd0);
    to  = !bad && (d >= T);
    rv  = !bad && !to;
    er  = rv ? sum : 16'h0;
    ef  = rv ? flg : 5'h0;

    enable = 1'b0; fpu_ready = 1'b0;
    repeat (LAT + 2) tick();

    press(a);
    checks++;
    if ({state_o, opa, result, flags, result_valid, timeout, op_err} !== {3'd1, a, 16'h0, 5'h0, 3'b000}) begin
      errors++;
      $display("FAIL %s got_a: got st=%0d opa=%h res=%h flg=%h rv/to/err=%b%b%b exp st=1 opa=%h cleared",
               nm, state_o, opa, result, flags, result_valid, timeout, op_err, a);
    end

    press(b);
    checks++;
    if ({state_o, opb} !== {3'd2, b}) begin
      errors++;
      $display("FAIL %s got_b: got st=%0d opb=%h exp st=2 opb=%h", nm, state_o, opb, b);
    end

    switches = opsw;
    enable   = 1'b1;
    for (int c = 0; c <= LAT; c++) begin
      checks++;
      if ({state_o, fpu_start, busy} !== {3'd2, 2'b00}) begin
        errors++;
        $display("FAIL %s third_press_c%0d: got st=%0d start=%b busy=%b exp st=2 start=0 busy=0",
                 nm, c, state_o, fpu_start, busy);
      end
      tick();
    end
    enable = 1'b0;

    if (bad) begin
      checks++;
      if ({state_o, op_err, fpu_start, busy, result, flags, timeout, result_valid} !==
          {3'd5, 3'b100, 16'h0, 5'h0, 2'b00}) begin
        errors++;
        $display("FAIL %s bad_op: got st=%0d err=%b start=%b busy=%b res=%h flg=%h to=%b rv=%b exp st=5 err=1 rest 0",
                 nm, state_o, op_err, fpu_start, busy, result, flags, timeout, result_valid);
      end
      tick();
      checks++;
      if ({state_o, fpu_start} !== {3'd5, 1'b0}) begin
        errors++;
        $display("FAIL %s bad_op_hold: got st=%0d start=%b exp st=5 start=0", nm, state_o, fpu_start);
      end
      return;
    end

    // ISSUE cycle: a stale ready here must not end the command.
    fpu_ready = 1'b1;
    fpu_sum   = 16'($urandom);
    fpu_flags = 5'($urandom);
    checks++;
    if ({state_o, fpu_start, busy, fpu_op, opa, opb} !== {3'd3, 2'b11, opsw[1:0], a, b}) begin
      errors++;
      $display("FAIL %s issue: got st=%0d start=%b busy=%b op=%0d opa=%h opb=%h exp st=3 start=1 busy=1 op=%0d opa=%h opb=%h",
               nm, state_o, fpu_start, busy, fpu_op, opa, opb, opsw[1:0], a, b);
    end

    fin = 1'b0;
    for (int k = 0; k < T && !fin; k++) begin
      tick();
      fpu_ready = (k == d);
      fpu_sum   = (k == d) ? sum : 16'($urandom);
      fpu_flags = (k == d) ? flg : 5'($urandom);
      enable    = (k == pw);
      checks++;
      if ({state_o, busy, fpu_start, result_valid, result, fpu_op, opa, opb} !==
          {3'd4, 3'b100, 16'h0, opsw[1:0], a, b}) begin
        errors++;
        $display("FAIL %s wait_k%0d: got st=%0d busy=%b start=%b rv=%b res=%h op=%0d opa=%h opb=%h exp st=4 busy=1 op=%0d opa=%h opb=%h",
                 nm, k, state_o, busy, fpu_start, result_valid, result, fpu_op, opa, opb, opsw[1:0], a, b);
      end
      if (k == d) fin = 1'b1;
    end

    tick();
    fpu_ready = 1'b0;
    enable    = 1'b0;
    checks++;
    if ({state_o, busy, fpu_start, result, flags, result_valid, timeout, op_err} !==
        {3'd5, 2'b00, er, ef, rv, to, 1'b0}) begin
      errors++;
      $display("FAIL %s done: got st=%0d busy=%b start=%b res=%h flg=%h rv=%b to=%b err=%b exp st=5 res=%h flg=%h rv=%b to=%b",
               nm, state_o, busy, fpu_start, result, flags, result_valid, timeout, op_err, er, ef, rv, to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; switches = 16'hFFFF;
    fpu_ready = 1'b0; fpu_sum = 16'h0; fpu_flags = 5'h0;
    repeat (3) tick();
    checks++;
    if ({state_o, opa, opb, fpu_op, fpu_start, result, flags, result_valid, busy, timeout, op_err} !== 67'h0) begin
      errors++;
      $display("FAIL reset_values: got st=%0d opa=%h opb=%h op=%0d start=%b res=%h flg=%h rv=%b busy=%b to=%b err=%b exp all 0",
               state_o, opa, opb, fpu_op, fpu_start, result, flags, result_valid, busy, timeout, op_err);
    end
    rst = 1'b0;
    repeat (LAT + 3) tick();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_held_enable: got st=%0d exp 0", state_o);
    end
    enable = 1'b0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_normal_add();
    run_txn("add", 16'h3C00, 16'h4000, 16'h0000, 3, 16'h4200, 5'h00, 99);
  endtask

  task automatic test_bad_opcode();
    run_txn("badop", 16'h1234, 16'h5678, 16'h0004, 0, 16'hBEEF, 5'h1F, 99);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 16'hAAAA, 16'h5555, 16'h0002, T + 5, 16'h7777, 5'h0A, 99);
  endtask

  task automatic test_ready_at_expiry();
    run_txn("ready_expiry", 16'h0101, 16'h0202, 16'h0003, T - 1, 16'hC0DE, 5'h15, T - 1);
    run_txn("press_in_wait", 16'h0F0F, 16'hF0F0, 16'h0001, 4, 16'h1357, 5'h03, 1);
  endtask

  task automatic test_rst_mid_wait();
    enable = 1'b0; fpu_ready = 1'b0;
    repeat (LAT + 2) tick();
    press(16'h1111);
    press(16'h2222);
    press(16'h0001);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL rst_mid_wait_setup: got st=%0d exp 4", state_o);
    end
    enable = 1'b1;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    checks++;
    if ({state_o, opa, opb, fpu_op, fpu_start, result, flags, result_valid, busy, timeout, op_err} !== 67'h0) begin
      errors++;
      $display("FAIL rst_mid_wait_clear: got st=%0d opa=%h opb=%h op=%0d start=%b res=%h rv=%b busy=%b exp all 0",
               state_o, opa, opb, fpu_op, fpu_start, result, result_valid, busy);
    end
    fpu_ready = 1'b1; fpu_sum = 16'h9999; fpu_flags = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({state_o, result, flags, result_valid, busy} !== 25'h0) begin
        errors++;
        $display("FAIL rst_mid_wait_late_ready%0d: got st=%0d res=%h flg=%h rv=%b busy=%b exp all 0",
                 i, state_o, result, flags, result_valid, busy);
      end
    end
    fpu_ready = 1'b0;
    enable    = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [15:0] a, b, op, s;
      logic [4:0]  f;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = ($urandom_range(0, 4) == 0) ? (16'($urandom) | 16'h0004) : 16'($urandom_range(0, 3));
      s  = 16'($urandom);
      f  = 5'($urandom);
      run_txn($sformatf("rand%0d", n), a, b, op, $urandom_range(0, T + 2), s, f, $urandom_range(0, T + 3));
    end
  endtask

`ifdef CALC_SEQ_DEBOUNCE_EN
  task automatic test_debounce();
    rst = 1'b1; enable = 1'b0; tick(); rst = 1'b0;
    repeat (DB + 2) tick();
    enable = 1'b1; repeat (2) tick();
    enable = 1'b0; repeat (DB + 4) tick();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL debounce_glitch: got st=%0d exp 0", state_o);
    end
    enable = 1'b1; repeat (DB) tick();
    enable = 1'b0; repeat (3 * DB) tick();
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL debounce_one_press: got st=%0d exp 1", state_o);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef CALC_SEQ_DEBOUNCE_EN
    test_debounce();
`endif
    test_normal_add();
    test_bad_opcode();
    test_timeout();
    test_ready_at_expiry();
    test_random();
    test_rst_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before abort.
REQ-002 Parameter DEBOUNCE_CYCLES, 4: stable-level cycles required by the debounce filter.
REQ-003 The clock is clk, input, 1 bit, rising-edge; the reset is rst, input, 1 bit, synchronous, active-high.
REQ-004 enable  in  1  push-button level used to step the sequencer.
REQ-005 switches  in  16  operand or opcode entry value.
REQ-006 fpu_ready  in  1  datapath result valid, sampled only in WAIT.
REQ-007 fpu_sum  in  16  datapath result.
REQ-008 fpu_flags  in  5  {underflow, overflow, inexact, exception, invalid}.
REQ-009 opa, opb  out  16 each  operand registers driven to the datapath.
REQ-010 fpu_op  out  2  00 add, 01 sub, 10 mul, 11 div.
REQ-011 fpu_start  out  1  one-cycle launch pulse.
REQ-012 result  out  16  latched result.
REQ-013 flags  out  5  latched fpu_flags, same bit order.
REQ-014 result_valid, busy, timeout, op_err  out  1 each  status.
REQ-015 state_o  out  3  current state encoding.

Function
REQ-016 Press = rising edge of the (filtered) enable level: registered enable_q, press = level & ~enable_q.
REQ-017 States: IDLE(0), GOT_A(1), GOT_B(2), ISSUE(3), WAIT(4), DONE(5); encodings 6-7 SHALL return to IDLE next cycle.
REQ-018 IDLE or DONE + press: opa <= switches, clear result_valid/timeout/op_err/result/flags, go GOT_A.
REQ-019 GOT_A + press: opb <= switches, go GOT_B.
REQ-020 GOT_B + press: switches[15:2] == 0 -> fpu_op <= switches[1:0], go ISSUE; else op_err=1, result=0, flags=0, go DONE, no fpu_start.
REQ-021 ISSUE: fpu_start=1 for exactly that cycle; go WAIT unconditionally; fpu_ready during ISSUE SHALL be ignored.
REQ-022 WAIT + fpu_ready: result <= fpu_sum, flags <= fpu_flags, result_valid=1 from next cycle, go DONE.
REQ-023 WAIT counter starts at 0 on entry, increments each cycle without fpu_ready; reaching TIMEOUT_CYCLES -> timeout=1, result=0, flags=0, go DONE.
REQ-024 fpu_ready and counter expiry in the same cycle: fpu_ready wins, timeout stays 0.
REQ-025 Presses in ISSUE and WAIT SHALL be ignored and not queued.
REQ-026 busy=1 exactly in ISSUE and WAIT; opa/opb/fpu_op SHALL remain stable from ISSUE until DONE exit.
REQ-027 Command latency: third press cycle -> fpu_start asserted on the following cycle.
REQ-028 Counter width is $clog2(TIMEOUT_CYCLES+1); no wrap-around is permitted.

Reset
REQ-029 rst SHALL force IDLE, with opa, opb, result, flags, fpu_op, fpu_start, result_valid, busy, timeout, op_err, WAIT counter and state_o all 0.
REQ-030 enable_q SHALL reset to 1, so an enable held high through reset produces no press.
REQ-031 rst in ISSUE/WAIT SHALL abort the operation; any later fpu_ready in IDLE SHALL be ignored.

Configuration
REQ-032 Macro CALC_SEQ_DEBOUNCE_EN defined: enable passes through a filter whose output changes only after DEBOUNCE_CYCLES consecutive cycles at the new level; the filter output resets to 1 and its counter resets to 0; press latency grows by DEBOUNCE_CYCLES.
REQ-033 Macro not defined: the raw enable feeds edge detection directly, and DEBOUNCE_CYCLES is unused.

Structure
REQ-034 Package calc_seq_pkg SHALL hold the state enum, opcode constants (OP_ADD..OP_DIV) and flag bit indices (FLG_UNDERFLOW=4 .. FLG_INVALID=0).
REQ-035 Sub-module calc_seq_debounce SHALL implement the filter, and SHALL be instantiated only under CALC_SEQ_DEBOUNCE_EN.

Verification
REQ-036 Normal add: presses with switches=0x3C00, 0x4000, 0x0000; fpu_ready after 3 WAIT cycles with fpu_sum=0x4200, flags=0 -> fpu_start 1 cycle, result=0x4200, result_valid=1, state_o=5.
REQ-037 Bad opcode: third press with switches=0x0004 -> op_err=1, no fpu_start, DONE.
REQ-038 Timeout: TIMEOUT_CYCLES=8, no fpu_ready -> timeout=1 after 8 WAIT cycles, result=0, busy falls.
REQ-039 Press during WAIT plus simultaneous fpu_ready/expiry -> press ignored, timeout=0, result latched.
REQ-040 rst pulse mid-WAIT with enable held high, then fpu_ready -> all outputs 0, state IDLE, no press registered.
REQ-041 CALC_SEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle enable glitch -> no transition; 4-cycle high -> exactly one press.
